// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI/I2C bridge.
//   spi_tx_state_t : state encoding of the SPI master transmitter FSM
//   SpiCpol/SpiCpha: SPI mode constants shared by transmitter and receiver (mode 0)
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift,
        StHold,
        StGap
    } spi_tx_state_t;

    localparam logic SpiCpol = 1'b0;
    localparam logic SpiCpha = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: divides wr_clk by 2*CLK_DIV while enabled.
//   wr_clk      in  system clock
//   wr_rst_n    in  asynchronous active-low reset
//   en_i        in  run the divider; when low, sclk parks at its idle level and the
//                   divider restarts so the first edge comes CLK_DIV cycles after enable
//   sclk_o      out registered SPI clock level
//   sclk_rise_o out strobe: sclk goes high at the end of this cycle
//   sclk_fall_o out strobe: sclk goes low at the end of this cycle
module spi_clk_gen
    import spi_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic wr_clk,
    input  logic wr_rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;
    logic            tick;

    assign tick = en_i && (cnt_q == CntW'(CLK_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = SpiCpol;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            cnt_q  <= '0;
            sclk_q <= SpiCpol;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign sclk_rise_o = tick && !sclk_q;
    assign sclk_fall_o = tick && sclk_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmitter, mode 0 (CPOL=0, CPHA=0), MSB first. Pops bytes from a TX FIFO
// read port and shifts them out under cs_n.
//   wr_clk, wr_rst_n   clock and asynchronous active-low reset
//   tx_enable          allows new frames and burst continuation
//   fifo_empty         TX FIFO empty flag
//   fifo_rd_data       FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en         single-cycle pop strobe
//   sclk, cs_n, mosi   SPI bus (all registered)
//   busy               first pop until end of the inter-frame gap
//   byte_done          pulse on the last sclk fall of each byte
//   frame_done         pulse in the cycle cs_n returns high
// Build option SPI_MASTER_TX_BURST_EN: when defined, queued bytes are prefetched on the
// last rising edge and sent back to back in one frame; otherwise every byte is its own frame.
module spi_master_tx
    import spi_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  busy,
    output logic                  byte_done,
    output logic                  frame_done
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Prefetched data needs at least one cycle of slack before the byte boundary.
    if (CLK_DIV < 2) begin : g_div_check
        $error("spi_master_tx: CLK_DIV must be at least 2");
    end
    if (SpiCpol != 1'b0 || SpiCpha != 1'b0) begin : g_mode_check
        $error("spi_master_tx: only SPI mode 0 is implemented");
    end

    spi_tx_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  byte_done_q, byte_done_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sclk_rise, sclk_fall;

`ifdef SPI_MASTER_TX_BURST_EN
    logic                  pf_q, pf_d;   // a prefetched byte is on its way
    logic                  cap_q;        // fifo_rd_data carries the prefetched byte this cycle
    logic [DATA_WIDTH-1:0] hold_q;
`endif

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .wr_clk     (wr_clk),
        .wr_rst_n   (wr_rst_n),
        .en_i       (state_q == StShift),
        .sclk_o     (sclk),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;
        rd_en_d      = 1'b0;
        busy_d       = busy_q;
        byte_done_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef SPI_MASTER_TX_BURST_EN
        pf_d         = pf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_enable && !fifo_empty) begin
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                shift_d   = fifo_rd_data;
                mosi_d    = fifo_rd_data[DATA_WIDTH-1];
                cs_n_d    = 1'b0;
                bit_cnt_d = '0;
                state_d   = StShift;
            end
            StShift: begin
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SPI_MASTER_TX_BURST_EN
                    // Last rising edge of the byte is the only point a burst may extend.
                    if (bit_cnt_q == BitW'(DATA_WIDTH - 1) && tx_enable && !fifo_empty) begin
                        rd_en_d = 1'b1;
                        pf_d    = 1'b1;
                    end
`endif
                end
                if (sclk_fall) begin
                    shift_d = shift_q << 1;
                    if (bit_cnt_q == BitW'(DATA_WIDTH)) begin
                        byte_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StHold;
`ifdef SPI_MASTER_TX_BURST_EN
                        if (pf_q) begin
                            // With CLK_DIV=2 the data arrives in this very cycle.
                            shift_d   = cap_q ? fifo_rd_data : hold_q;
                            bit_cnt_d = '0;
                            pf_d      = 1'b0;
                            state_d   = StShift;
                        end
`endif
                    end
                    mosi_d = shift_d[DATA_WIDTH-1];
                end
            end
            StHold: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(CLK_DIV - 1)) begin
                    cnt_d        = '0;
                    cs_n_d       = 1'b1;
                    mosi_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = StGap;
                end
            end
            StGap: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            cnt_q        <= '0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cnt_q        <= cnt_d;
            cs_n_q       <= cs_n_d;
            mosi_q       <= mosi_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            byte_done_q  <= byte_done_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef SPI_MASTER_TX_BURST_EN
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            pf_q   <= 1'b0;
            cap_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            pf_q  <= pf_d;
            cap_q <= rd_en_q && (state_q == StShift);
            if (cap_q) begin
                hold_q <= fifo_rd_data;
            end
        end
    end
`endif

    assign fifo_rd_en = rd_en_q;
    assign cs_n       = cs_n_q;
    assign mosi       = mosi_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: FIFO model, bus monitor that decodes frames, and a frame-level
// reference (cs_n low time, edge count and byte content per frame) built from pushed bytes.
module tb_spi_master_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned CD = 4;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          tx_enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en, sclk, cs_n, mosi, busy, byte_done, frame_done;

    always #5 wr_clk = ~wr_clk;

    spi_master_tx #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst_n    (wr_rst_n),
        .tx_enable   (tx_enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .busy        (busy),
        .byte_done   (byte_done),
        .frame_done  (frame_done)
    );

    // FIFO model: one-cycle write latency, read data valid the cycle after the pop.
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_byte = '0;
    logic [DW-1:0] fifo_q[$];
    int            pop_cnt = 0;
    int            empty_pop = 0;

    always @(posedge wr_clk) begin
        if (fifo_rd_en) begin
            pop_cnt++;
            if (fifo_q.size() == 0) empty_pop++;
            else fifo_rd_data <= fifo_q.pop_front();
        end
        if (wr_valid) fifo_q.push_back(wr_byte);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Bus monitor.
    int            cyc = 0;
    logic          prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    bit            in_frame = 1'b0;
    int            cur_len = 0, cur_first = -1, cur_rises = 0, cur_nbytes = 0, nbits = 0;
    logic [DW-1:0] cur_byte = '0;
    int            f_len[$], f_first[$], f_rises[$], f_nbytes[$], lat_q[$];
    logic [DW-1:0] rx_q[$];
    int            rd_idle_cyc = -1, last_end = -1;
    int            bd_cnt = 0, fd_cnt = 0, proto_err = 0, gap_err = 0;

    always @(negedge wr_clk) begin
        cyc++;
        if (!wr_rst_n) begin
            in_frame    = 1'b0;
            nbits       = 0;
            rd_idle_cyc = -1;
            last_end    = -1;
            prev_cs     = 1'b1;
            prev_sclk   = 1'b0;
            prev_mosi   = 1'b0;
        end else begin
            if (byte_done) bd_cnt++;
            if (frame_done) fd_cnt++;
            if (fifo_rd_en && fifo_empty) proto_err++;
            if (cs_n && (mosi || sclk)) proto_err++;
            if (!cs_n && !prev_cs && mosi !== prev_mosi && !(prev_sclk && !sclk)) proto_err++;
            if (frame_done !== (cs_n && !prev_cs && in_frame)) proto_err++;
            if (fifo_rd_en && cs_n) rd_idle_cyc = cyc;
            if (!cs_n && prev_cs) begin
                in_frame   = 1'b1;
                cur_len    = 0;
                cur_first  = -1;
                cur_rises  = 0;
                cur_nbytes = 0;
                nbits      = 0;
                lat_q.push_back(cyc - rd_idle_cyc);
                if (last_end >= 0 && cyc - last_end < int'(CD)) gap_err++;
            end
            if (!cs_n && in_frame) begin
                if (sclk && !prev_sclk) begin
                    if (cur_first < 0) cur_first = cur_len;
                    cur_rises++;
                    cur_byte = {cur_byte[DW-2:0], mosi};
                    nbits++;
                    if (nbits == DW) begin
                        rx_q.push_back(cur_byte);
                        cur_nbytes++;
                        nbits = 0;
                    end
                end
                cur_len++;
            end
            if (cs_n && !prev_cs && in_frame) begin
                f_len.push_back(cur_len);
                f_first.push_back(cur_first);
                f_rises.push_back(cur_rises);
                f_nbytes.push_back(cur_nbytes);
                in_frame = 1'b0;
                last_end = cyc;
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
    end

    // Checking.
    int            n_checks = 0, n_pass = 0;
    int            f_base, rx_base, bd_base, fd_base, lat_base;
    int            exp_nbytes[$];
    logic [DW-1:0] exp_bytes[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mark();
        f_base   = f_len.size();
        rx_base  = rx_q.size();
        bd_base  = bd_cnt;
        fd_base  = fd_cnt;
        lat_base = lat_q.size();
        exp_nbytes.delete();
        exp_bytes.delete();
    endtask

    task automatic push(input logic [DW-1:0] v);
        @(negedge wr_clk);
        wr_valid = 1'b1;
        wr_byte  = v;
        @(negedge wr_clk);
        wr_valid = 1'b0;
    endtask

    // Reference grouping: bytes queued together share a frame only with burst enabled.
    task automatic add_group(input int k);
`ifdef SPI_MASTER_TX_BURST_EN
        exp_nbytes.push_back(k);
`else
        for (int i = 0; i < k; i++) exp_nbytes.push_back(1);
`endif
    endtask

    task automatic wait_idle(input int max_cyc);
        int stable = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge wr_clk);
            if (fifo_empty && !busy && cs_n && !wr_valid) stable++;
            else stable = 0;
            if (stable >= 3) return;
        end
        check("idle_timeout", stable, 3);
    endtask

    task automatic wait_rises(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge wr_clk);
            if (in_frame && cur_rises == n) return;
        end
        check("rise_timeout", cur_rises, n);
    endtask

    task automatic wait_frames(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge wr_clk);
            if (f_len.size() - f_base >= n) return;
        end
        check("frame_timeout", f_len.size() - f_base, n);
    endtask

    task automatic verify(input string tag);
        int nf, nb;
        nf = f_len.size() - f_base;
        nb = rx_q.size() - rx_base;
        check({tag, ":frames"}, nf, exp_nbytes.size());
        for (int i = 0; i < exp_nbytes.size() && i < nf; i++) begin
            check({tag, ":cs_low_cycles"}, f_len[f_base+i], (2 * DW * exp_nbytes[i] + 1) * CD);
            check({tag, ":rises"}, f_rises[f_base+i], DW * exp_nbytes[i]);
            check({tag, ":first_rise"}, f_first[f_base+i], CD);
            check({tag, ":frame_bytes"}, f_nbytes[f_base+i], exp_nbytes[i]);
            if (lat_base + i < lat_q.size()) check({tag, ":pop_to_cs"}, lat_q[lat_base+i], 2);
        end
        check({tag, ":bytes"}, nb, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < nb; i++) begin
            check({tag, ":data"}, rx_q[rx_base+i], exp_bytes[i]);
        end
        check({tag, ":byte_done"}, bd_cnt - bd_base, exp_bytes.size());
        check({tag, ":frame_done"}, fd_cnt - fd_base, exp_nbytes.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] b0, b1, rv;
        int k, pops;

        // Reset values.
        repeat (3) @(negedge wr_clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_byte_done", byte_done, 0);
        check("rst_frame_done", frame_done, 0);
        wr_rst_n  = 1'b1;
        tx_enable = 1'b1;
        repeat (2) @(negedge wr_clk);

        // Single byte 0xA5.
        mark();
        push(8'hA5);
        exp_nbytes.push_back(1);
        exp_bytes.push_back(8'hA5);
        wait_idle(400);
        verify("single");

        // Three queued bytes.
        mark();
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        add_group(3);
        exp_bytes.push_back(8'h01);
        exp_bytes.push_back(8'h80);
        exp_bytes.push_back(8'hFF);
        wait_idle(1000);
        verify("three");

        // Random groups.
        for (int r = 0; r < 4; r++) begin
            mark();
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                rv = 8'($urandom);
                push(rv);
                exp_bytes.push_back(rv);
            end
            add_group(k);
            wait_idle(1500);
            verify("random");
        end

        // Byte written after the last rising edge starts its own frame.
        mark();
        push(8'h11);
        wait_rises(DW, 400);
        push(8'h3C);
        exp_nbytes.push_back(1);
        exp_nbytes.push_back(1);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h3C);
        wait_idle(600);
        verify("late");

        // tx_enable dropped mid-byte with a second byte queued.
        mark();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        push(b0);
        push(b1);
        wait_rises(3, 400);
        @(negedge wr_clk);
        tx_enable = 1'b0;
        pops      = pop_cnt;
        wait_frames(1, 300);
        repeat (40) @(negedge wr_clk);
        check("txen:frames_while_off", f_len.size() - f_base, 1);
        check("txen:pops_while_off", pop_cnt - pops, 0);
        check("txen:fifo_kept", fifo_empty, 0);
        check("txen:busy_off", busy, 0);
        tx_enable = 1'b1;
        exp_nbytes.push_back(1);
        exp_nbytes.push_back(1);
        exp_bytes.push_back(b0);
        exp_bytes.push_back(b1);
        wait_idle(600);
        verify("txen");

        // Reset during bit 4: popped byte lost, remaining byte sent in a new frame.
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        push(b0);
        push(b1);
        wait_rises(4, 400);
        @(negedge wr_clk);
        #1 wr_rst_n = 1'b0;
        #1;
        check("arst_cs_n", cs_n, 1);
        check("arst_sclk", sclk, 0);
        check("arst_mosi", mosi, 0);
        check("arst_busy", busy, 0);
        check("arst_rd_en", fifo_rd_en, 0);
        repeat (2) @(negedge wr_clk);
        wr_rst_n = 1'b1;
        mark();
        exp_nbytes.push_back(1);
        exp_bytes.push_back(b1);
        wait_idle(600);
        verify("arst");

        // Protocol invariants over the whole run.
        check("protocol_errors", proto_err, 0);
        check("pop_while_empty", empty_pop, 0);
        check("short_cs_gap", gap_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
